// File: rtl/dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
//
// Purpose:
//   Shared constants and types for the data-memory arbiter. The arbiter
//   shares one single-port syncram between the processor M stage and two
//   external requesters (VGA frame reader, game/collision engine).
//
// Contents:
//   DMEM_ADDR_W        default memory address width
//   DMEM_DATA_W        default memory word width
//   DMEM_STARVE_LIMIT  default wait count at which a starve flag asserts
//   DMEM_CNT_W         width of the per-port wait counters
//   port_idx_t         identifies which requester owns the memory port
//   sat_inc            saturating increment used by the wait counters
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

    localparam int DMEM_ADDR_W       = 12;
    localparam int DMEM_DATA_W       = 32;
    localparam int DMEM_STARVE_LIMIT = 64;
    localparam int DMEM_CNT_W        = 7;

    typedef enum logic [1:0] {
        PORT_CPU  = 2'd0,
        PORT_EXT0 = 2'd1,
        PORT_EXT1 = 2'd2,
        PORT_NONE = 2'd3
    } port_idx_t;

    // Increment v by one, but never past lim.
    function automatic logic [DMEM_CNT_W-1:0] sat_inc(
        input logic [DMEM_CNT_W-1:0] v,
        input logic [DMEM_CNT_W-1:0] lim
    );
        logic [DMEM_CNT_W-1:0] r;
        r = (v >= lim) ? lim : v + 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/dmem_arbiter_starve_ctr.sv
// -----------------------------------------------------------------------------
// arb_starve_ctr
//
// Purpose:
//   Per-port wait counter. Counts consecutive cycles in which the port
//   requests the memory but is not granted, saturating at LIMIT. The starve
//   flag is purely a status output; it never influences arbitration.
//
// Ports:
//   clock     system clock
//   reset     synchronous, active-high reset (clears the counter)
//   req_i     port is requesting this cycle
//   gnt_i     port is granted this cycle
//   starve_o  counter has reached LIMIT (decoded from the count register)
// -----------------------------------------------------------------------------
module arb_starve_ctr
    import dmem_arb_pkg::*;
#(
    parameter int LIMIT = DMEM_STARVE_LIMIT
) (
    input  logic clock,
    input  logic reset,
    input  logic req_i,
    input  logic gnt_i,
    output logic starve_o
);

    localparam logic [DMEM_CNT_W-1:0] LIMIT_C = DMEM_CNT_W'(LIMIT);

    logic [DMEM_CNT_W-1:0] cnt_q;
    logic [DMEM_CNT_W-1:0] cnt_d;

    // A grant or a dropped request ends the wait, so the count restarts.
    always_comb begin
        cnt_d = cnt_q;
        if (!req_i || gnt_i) begin
            cnt_d = '0;
        end else begin
            cnt_d = sat_inc(cnt_q, LIMIT_C);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Decoded from the register only, so the flag is glitch-free.
    assign starve_o = (cnt_q == LIMIT_C);

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Purpose:
//   Shares the single-port data syncram between the processor M stage and
//   two external requesters. The CPU has absolute priority and is never
//   stalled. The external ports use a req/gnt handshake with a one-bit
//   round-robin pointer breaking ties between them. Read data comes straight
//   from the syncram q with one cycle of latency; external reads are tagged
//   by a per-port rvalid.
//
// Ports:
//   clock, reset                  clock and synchronous active-high reset
//   cpu_req/we/addr/wdata         processor access (not stallable)
//   cpu_rdata                     syncram q, forwarded unregistered
//   extN_req/we/addr/wdata        external request, held until gnt
//   extN_gnt                      combinational; access happens at this edge
//   extN_rvalid                   registered; extN_rdata valid this cycle
//   extN_rdata                    syncram q
//   extN_starve                   registered; port has waited STARVE_LIMIT
//   mem_address/mem_data/mem_wren syncram command port
//   mem_q                         syncram registered read data
// -----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W       = DMEM_ADDR_W,
    parameter int DATA_W       = DMEM_DATA_W,
    parameter int STARVE_LIMIT = DMEM_STARVE_LIMIT
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,

    input  logic              ext0_req,
    input  logic              ext0_we,
    input  logic [ADDR_W-1:0] ext0_addr,
    input  logic [DATA_W-1:0] ext0_wdata,
    output logic              ext0_gnt,
    output logic              ext0_rvalid,
    output logic [DATA_W-1:0] ext0_rdata,
    output logic              ext0_starve,

    input  logic              ext1_req,
    input  logic              ext1_we,
    input  logic [ADDR_W-1:0] ext1_addr,
    input  logic [DATA_W-1:0] ext1_wdata,
    output logic              ext1_gnt,
    output logic              ext1_rvalid,
    output logic [DATA_W-1:0] ext1_rdata,
    output logic              ext1_starve,

    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q
);

    localparam int N_EXT = 2;

    // External ports gathered into vectors so per-port logic is generated.
    logic [N_EXT-1:0]  ext_req;
    logic [N_EXT-1:0]  ext_we;
    logic [N_EXT-1:0]  ext_gnt;
    logic [N_EXT-1:0]  ext_starve;
    logic [ADDR_W-1:0] ext_addr  [N_EXT];
    logic [DATA_W-1:0] ext_wdata [N_EXT];

    logic [N_EXT-1:0]  rvalid_q;
    logic [N_EXT-1:0]  rvalid_d;
    logic              rr_q;
    logic              rr_d;
    port_idx_t         winner;

    assign ext_req      = {ext1_req, ext0_req};
    assign ext_we       = {ext1_we, ext0_we};
    assign ext_addr[0]  = ext0_addr;
    assign ext_addr[1]  = ext1_addr;
    assign ext_wdata[0] = ext0_wdata;
    assign ext_wdata[1] = ext1_wdata;

    // -------------------------------------------------------------------------
    // Winner selection. Nothing wins while reset is high, so no grant and no
    // write can leak out during reset. rr_q=0 favours ext0 on a tie.
    // -------------------------------------------------------------------------
    always_comb begin
        winner = PORT_NONE;
        if (!reset) begin
            if (cpu_req) begin
                winner = PORT_CPU;
            end else if (ext_req[0] && ext_req[1]) begin
                winner = rr_q ? PORT_EXT1 : PORT_EXT0;
            end else if (ext_req[0]) begin
                winner = PORT_EXT0;
            end else if (ext_req[1]) begin
                winner = PORT_EXT1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Memory command mux. With no winner the CPU inputs are presented, which
    // keeps the address path identical to a direct CPU connection when idle.
    // -------------------------------------------------------------------------
    always_comb begin
        mem_address = cpu_addr;
        mem_data    = cpu_wdata;
        mem_wren    = 1'b0;
        case (winner)
            PORT_CPU: begin
                mem_wren = cpu_we;
            end
            PORT_EXT0: begin
                mem_address = ext_addr[0];
                mem_data    = ext_wdata[0];
                mem_wren    = ext_we[0];
            end
            PORT_EXT1: begin
                mem_address = ext_addr[1];
                mem_data    = ext_wdata[1];
                mem_wren    = ext_we[1];
            end
            default: begin
                mem_wren = 1'b0;
            end
        endcase
        if (reset) begin
            mem_wren = 1'b0;
        end
    end

    assign ext_gnt[0] = (winner == PORT_EXT0);
    assign ext_gnt[1] = (winner == PORT_EXT1);

    // Pointer moves to whichever ext port was not just served; CPU cycles and
    // idle cycles leave it alone.
    always_comb begin
        rr_d = rr_q;
        if (ext_gnt[0]) begin
            rr_d = 1'b1;
        end else if (ext_gnt[1]) begin
            rr_d = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Per-port read tagging and wait counters.
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < N_EXT; gi++) begin : g_ext
            // A granted read returns on the syncram q one edge later.
            assign rvalid_d[gi] = ext_gnt[gi] & ~ext_we[gi];

            arb_starve_ctr #(
                .LIMIT (STARVE_LIMIT)
            ) u_starve (
                .clock    (clock),
                .reset    (reset),
                .req_i    (ext_req[gi]),
                .gnt_i    (ext_gnt[gi]),
                .starve_o (ext_starve[gi])
            );
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_q     <= 1'b0;
            rvalid_q <= '0;
        end else begin
            rr_q     <= rr_d;
            rvalid_q <= rvalid_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs. All read data is the raw syncram q; rvalid says whose it is.
    // -------------------------------------------------------------------------
    assign cpu_rdata   = mem_q;
    assign ext0_rdata  = mem_q;
    assign ext1_rdata  = mem_q;
    assign ext0_gnt    = ext_gnt[0];
    assign ext1_gnt    = ext_gnt[1];
    assign ext0_rvalid = rvalid_q[0];
    assign ext1_rvalid = rvalid_q[1];
    assign ext0_starve = ext_starve[0];
    assign ext1_starve = ext_starve[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Drives the arbiter together with a behavioural syncram. Each cycle a
// reference model predicts the winner, memory command, read returns and
// starve flags; read returns go through a scoreboard queue and are compared
// one edge later. A vector table and hand-written sequences add fixed
// expected values for the key scenarios.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int LIM = 64;

    logic          clock = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          ext0_req, ext0_we, ext0_gnt, ext0_rvalid, ext0_starve;
    logic [AW-1:0] ext0_addr;
    logic [DW-1:0] ext0_wdata, ext0_rdata;
    logic          ext1_req, ext1_we, ext1_gnt, ext1_rvalid, ext1_starve;
    logic [AW-1:0] ext1_addr;
    logic [DW-1:0] ext1_wdata, ext1_rdata;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data, mem_q;
    logic          mem_wren;

    always #5 clock = ~clock;

    dmem_arbiter dut (
        .clock       (clock),
        .reset       (reset),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .ext0_req    (ext0_req),
        .ext0_we     (ext0_we),
        .ext0_addr   (ext0_addr),
        .ext0_wdata  (ext0_wdata),
        .ext0_gnt    (ext0_gnt),
        .ext0_rvalid (ext0_rvalid),
        .ext0_rdata  (ext0_rdata),
        .ext0_starve (ext0_starve),
        .ext1_req    (ext1_req),
        .ext1_we     (ext1_we),
        .ext1_addr   (ext1_addr),
        .ext1_wdata  (ext1_wdata),
        .ext1_gnt    (ext1_gnt),
        .ext1_rvalid (ext1_rvalid),
        .ext1_rdata  (ext1_rdata),
        .ext1_starve (ext1_starve),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .mem_wren    (mem_wren),
        .mem_q       (mem_q)
    );

    function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
        return {20'hC0DE0, a};
    endfunction

    // Behavioural syncram: registered read of the old contents.
    logic [DW-1:0] smem [logic [AW-1:0]];
    always @(posedge clock) begin
        logic [DW-1:0] rd;
        rd = smem.exists(mem_address) ? smem[mem_address] : init_word(mem_address);
        if (mem_wren) smem[mem_address] = mem_data;
        mem_q <= rd;
    end

    // ---------------- reference model state ----------------
    typedef struct {
        port_idx_t     port;
        logic [DW-1:0] data;
    } sb_t;

    sb_t           sb [$];
    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    logic          rr_m;
    int            cnt_m [2];
    int            checks = 0;
    int            errors = 0;
    logic          obs_g0, obs_g1, obs_wren;
    int            cyc = 0;

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h want %h", name, cyc, act, exp);
        end
    endtask

    task automatic set_cpu(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cpu_req = r; cpu_we = w; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic set_ext(input int n, input logic r, input logic w,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (n == 0) begin
            ext0_req = r; ext0_we = w; ext0_addr = a; ext0_wdata = d;
        end else begin
            ext1_req = r; ext1_we = w; ext1_addr = a; ext1_wdata = d;
        end
    endtask

    task automatic idle();
        set_cpu(1'b0, 1'b0, '0, '0);
        set_ext(0, 1'b0, 1'b0, '0, '0);
        set_ext(1, 1'b0, 1'b0, '0, '0);
    endtask

    // One clock cycle: check the combinational command against the model,
    // cross the edge, then check registered outputs and read returns.
    task automatic step(input string tag);
        port_idx_t     w;
        logic          ewren;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic          rq, gn;
        logic          erv0, erv1, ecpu;
        logic [DW-1:0] ed0, ed1, edc;
        sb_t           e;
        #3;
        w = PORT_NONE;
        if (!reset) begin
            if (cpu_req)                   w = PORT_CPU;
            else if (ext0_req && ext1_req) w = rr_m ? PORT_EXT1 : PORT_EXT0;
            else if (ext0_req)             w = PORT_EXT0;
            else if (ext1_req)             w = PORT_EXT1;
        end
        ea = cpu_addr; ed = cpu_wdata; ewren = 1'b0;
        if (w == PORT_CPU)  begin ewren = cpu_we; end
        if (w == PORT_EXT0) begin ea = ext0_addr; ed = ext0_wdata; ewren = ext0_we; end
        if (w == PORT_EXT1) begin ea = ext1_addr; ed = ext1_wdata; ewren = ext1_we; end
        obs_g0 = ext0_gnt; obs_g1 = ext1_gnt; obs_wren = mem_wren;
        chk("gnt0", 64'(ext0_gnt), 64'(w == PORT_EXT0));
        chk("gnt1", 64'(ext1_gnt), 64'(w == PORT_EXT1));
        chk("mem_wren", 64'(mem_wren), 64'(ewren));
        chk("mem_address", 64'(mem_address), 64'(ea));
        chk("mem_data", 64'(mem_data), 64'(ed));
        $display("cyc %0d %s rst=%0b cpu=%0b e0=%0b e1=%0b gnt=%0b%0b wren=%0b addr=%h data=%h",
                 cyc, tag, reset, cpu_req, ext0_req, ext1_req, ext1_gnt, ext0_gnt,
                 mem_wren, mem_address, mem_data);
        if (w != PORT_NONE && !ewren) begin
            e.port = w; e.data = ref_rd(ea);
            sb.push_back(e);
        end
        if (w != PORT_NONE && ewren) ref_mem[ea] = ed;
        for (int n = 0; n < 2; n++) begin
            rq = (n == 0) ? ext0_req : ext1_req;
            gn = (n == 0) ? (w == PORT_EXT0) : (w == PORT_EXT1);
            if (reset || !rq || gn) cnt_m[n] = 0;
            else if (cnt_m[n] < LIM) cnt_m[n] = cnt_m[n] + 1;
        end
        if (reset)               rr_m = 1'b0;
        else if (w == PORT_EXT0) rr_m = 1'b1;
        else if (w == PORT_EXT1) rr_m = 1'b0;

        @(posedge clock);
        #1;
        cyc++;
        erv0 = 1'b0; erv1 = 1'b0; ecpu = 1'b0; ed0 = '0; ed1 = '0; edc = '0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.port == PORT_EXT0) begin erv0 = 1'b1; ed0 = e.data; end
            if (e.port == PORT_EXT1) begin erv1 = 1'b1; ed1 = e.data; end
            if (e.port == PORT_CPU)  begin ecpu = 1'b1; edc = e.data; end
        end
        chk("rvalid0", 64'(ext0_rvalid), 64'(erv0));
        chk("rvalid1", 64'(ext1_rvalid), 64'(erv1));
        if (erv0) chk("rdata0", 64'(ext0_rdata), 64'(ed0));
        if (erv1) chk("rdata1", 64'(ext1_rdata), 64'(ed1));
        if (ecpu) chk("cpu_rdata", 64'(cpu_rdata), 64'(edc));
        chk("starve0", 64'(ext0_starve), 64'(cnt_m[0] == LIM));
        chk("starve1", 64'(ext1_starve), 64'(cnt_m[1] == LIM));
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        step("reset");
        step("reset");
        reset = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic cr, cw, r0, w0, r1, w1;
        logic eg0, eg1, ewr;
    } vec_t;

    vec_t vecs [12];

    initial begin
        //            cr   cw   r0   w0   r1   w1   eg0  eg1  ewr
        vecs[0]  = '{1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0};
        vecs[1]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1};
        vecs[2]  = '{1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0};
        vecs[3]  = '{1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0};
        vecs[4]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b1,1'b1};
        vecs[5]  = '{1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0};
        vecs[6]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0};
        vecs[7]  = '{1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0};
        vecs[8]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
        vecs[9]  = '{1'b1,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1};
        vecs[10] = '{1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,1'b1,1'b0,1'b1};
        vecs[11] = '{1'b0,1'b0,1'b1,1'b0,1'b1,1'b1,1'b0,1'b1,1'b1};

        rr_m = 1'b0; cnt_m[0] = 0; cnt_m[1] = 0;
        idle();
        reset = 1'b1;

        // Reset with both ext ports requesting: no grant until release.
        set_ext(0, 1'b1, 1'b0, 12'h020, '0);
        set_ext(1, 1'b1, 1'b0, 12'h021, '0);
        step("rst_req");
        chk("rst gnt0", 64'(obs_g0), 64'd0);
        chk("rst gnt1", 64'(obs_g1), 64'd0);
        step("rst_req");
        chk("rst starve0", 64'(ext0_starve), 64'd0);
        chk("rst rvalid0", 64'(ext0_rvalid), 64'd0);
        reset = 1'b0;
        step("rel");
        chk("rel first gnt0", 64'(obs_g0), 64'd1);
        step("rel");
        chk("rel second gnt1", 64'(obs_g1), 64'd1);

        // Table-driven winner selection.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            set_cpu(vecs[i].cr, vecs[i].cw, AW'(12'h100 + i), 32'hA000_0000 + i);
            set_ext(0, vecs[i].r0, vecs[i].w0, AW'(12'h200 + i), 32'hB000_0000 + i);
            set_ext(1, vecs[i].r1, vecs[i].w1, AW'(12'h300 + i), 32'hC000_0000 + i);
            step("vec");
            chk("vec gnt0", 64'(obs_g0), 64'(vecs[i].eg0));
            chk("vec gnt1", 64'(obs_g1), 64'(vecs[i].eg1));
            chk("vec wren", 64'(obs_wren), 64'(vecs[i].ewr));
        end

        // CPU write beats a concurrent ext0 read of the same address.
        do_reset();
        set_cpu(1'b1, 1'b1, 12'h010, 32'hDEADBEEF);
        set_ext(0, 1'b1, 1'b0, 12'h010, '0);
        step("cpu_wr");
        chk("cpuwr wren", 64'(obs_wren), 64'd1);
        chk("cpuwr gnt0", 64'(obs_g0), 64'd0);
        set_cpu(1'b0, 1'b0, '0, '0);
        step("e0_rd");
        chk("e0rd gnt0", 64'(obs_g0), 64'd1);
        chk("e0rd rvalid", 64'(ext0_rvalid), 64'd1);
        chk("e0rd rdata", 64'(ext0_rdata), 64'(32'hDEADBEEF));
        idle();
        step("idle");

        // Continuous reads from both ports alternate.
        do_reset();
        set_ext(0, 1'b1, 1'b0, 12'h001, '0);
        set_ext(1, 1'b1, 1'b0, 12'h002, '0);
        for (int k = 0; k < 6; k++) begin
            step("alt");
            chk("alt gnt0", 64'(obs_g0), 64'(k % 2 == 0));
            chk("alt gnt1", 64'(obs_g1), 64'(k % 2 == 1));
            chk("alt rvalid0", 64'(ext0_rvalid), 64'(k % 2 == 0));
            chk("alt rvalid1", 64'(ext1_rvalid), 64'(k % 2 == 1));
            chk("alt rdata", 64'(ext0_rdata),
                64'((k % 2 == 0) ? init_word(12'h001) : init_word(12'h002)));
        end
        idle();
        step("idle");

        // Starvation of ext1 behind a long CPU burst.
        do_reset();
        set_cpu(1'b1, 1'b0, 12'h040, '0);
        set_ext(1, 1'b1, 1'b0, 12'h041, '0);
        for (int k = 1; k <= 70; k++) begin
            step("starve");
            if (k == 63) chk("starve1 at 63", 64'(ext1_starve), 64'd0);
            if (k == 64) chk("starve1 at 64", 64'(ext1_starve), 64'd1);
        end
        set_cpu(1'b0, 1'b0, '0, '0);
        step("starve_rel");
        chk("starve rel gnt1", 64'(obs_g1), 64'd1);
        chk("starve1 cleared", 64'(ext1_starve), 64'd0);
        idle();
        step("idle");

        // Reset right after an ext0 read grant.
        do_reset();
        set_ext(0, 1'b1, 1'b0, 12'h030, '0);
        step("e0_rd");
        chk("pre-rst gnt0", 64'(obs_g0), 64'd1);
        set_ext(0, 1'b0, 1'b0, '0, '0);
        set_cpu(1'b1, 1'b1, 12'h031, 32'h1111_1111);
        reset = 1'b1;
        step("mid_rst");
        chk("mid-rst wren", 64'(obs_wren), 64'd0);
        chk("mid-rst rvalid0", 64'(ext0_rvalid), 64'd0);
        reset = 1'b0;
        set_cpu(1'b0, 1'b0, '0, '0);
        set_ext(0, 1'b1, 1'b0, 12'h032, '0);
        set_ext(1, 1'b1, 1'b0, 12'h033, '0);
        step("post_rst");
        chk("post-rst rr gnt0", 64'(obs_g0), 64'd1);
        idle();
        step("idle");

        // ext1 write then read-back.
        do_reset();
        set_ext(1, 1'b1, 1'b1, 12'h0A5, 32'h12345678);
        step("e1_wr");
        chk("e1wr gnt1", 64'(obs_g1), 64'd1);
        chk("e1wr no rvalid", 64'(ext1_rvalid), 64'd0);
        set_ext(1, 1'b1, 1'b0, 12'h0A5, '0);
        step("e1_rd");
        chk("e1rd gnt1", 64'(obs_g1), 64'd1);
        chk("e1rd rvalid", 64'(ext1_rvalid), 64'd1);
        chk("e1rd rdata", 64'(ext1_rdata), 64'(32'h12345678));
        idle();
        step("idle");
        chk("e1 rvalid one cycle", 64'(ext1_rvalid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory (12-bit address, 32-bit word syncram) between the processor's memory stage and two external requesters: the VGA frame reader and the game/collision engine.
- The processor has absolute priority every cycle; it cannot be stalled by this block.
- The external ports use a req/gnt handshake with round-robin fairness between them.
- Read data returns with a fixed 1-cycle latency, tagged by a per-port rvalid.

Parameters:
- ADDR_W, 12, memory address width
- DATA_W, 32, memory word width
- STARVE_LIMIT, 64, consecutive denied cycles before a port's starve flag asserts

Ports:
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  processor accesses memory this cycle (lw or sw in M stage)
- cpu_we  in  1  processor write enable (sw)
- cpu_addr  in  ADDR_W  processor address
- cpu_wdata  in  DATA_W  processor write data
- cpu_rdata  out  DATA_W  memory q, forwarded unregistered
- ext0_req, ext1_req  in  1  external request; must hold until gnt
- ext0_we, ext1_we  in  1  external write enable
- ext0_addr, ext1_addr  in  ADDR_W  external address
- ext0_wdata, ext1_wdata  in  DATA_W  external write data
- ext0_gnt, ext1_gnt  out  1  combinational; access performed at this clock edge
- ext0_rvalid, ext1_rvalid  out  1  registered; read data valid this cycle
- ext0_rdata, ext1_rdata  out  DATA_W  memory q, valid when rvalid is high
- ext0_starve, ext1_starve  out  1  registered; wait counter has reached STARVE_LIMIT
- mem_address  out  ADDR_W  to syncram
- mem_data  out  DATA_W  to syncram
- mem_wren  out  1  to syncram

Behaviour:
- Winner selection (combinational):
  - If cpu_req is high, the CPU wins; no ext gnt is asserted.
  - Otherwise the requesting ext port is granted.
  - If both ext ports request, the port indicated by rr_ptr is granted.
  - If nothing is granted, mem_wren=0 and mem_address/mem_data hold the CPU inputs.
- Memory port mux: mem_address, mem_data and mem_wren come from the winner. mem_wren equals the winner's we, and is forced to 0 while reset is high.
- rr_ptr (1 bit):
  - Toggles to the non-granted port after each ext grant.
  - Unchanged when the CPU wins or when no ext port is granted.
  - Reset value 0, so ext0 is preferred first.
- Handshake:
  - Requester holds req/we/addr/wdata stable until it samples gnt=1 at a rising edge.
  - It may deassert req in the following cycle or issue its next request back-to-back.
  - gnt may assert in the same cycle req rises.
- Read return:
  - On an ext grant with we=0, the matching extN_rvalid is high exactly 1 cycle later, for one cycle.
  - Back-to-back reads give rvalid on consecutive cycles.
  - Writes never produce rvalid.
  - CPU reads have no valid flag; cpu_rdata is meaningful in the cycle after cpu_req, as for the existing M stage.
- Starvation counters (one per ext port, 7 bits, saturating at STARVE_LIMIT):
  - Increment each cycle the port has req=1 and gnt=0.
  - Clear to 0 on that port's gnt or when req=0.
  - extN_starve = (count == STARVE_LIMIT).
  - Status only; it does not alter priority.
- Reset (synchronous, valid mid-transaction):
  - All gnt, rvalid and starve outputs read 0 in the cycle after reset is sampled.
  - rr_ptr=0, counters=0, any pending rvalid is dropped.
  - No grant is issued while reset is high.
- Simultaneous events:
  - cpu_req with both ext requests: CPU wins; both counters increment; rr_ptr unchanged.
  - ext write and a pending rvalid for the same port in the same cycle is legal; the rvalid refers to the earlier read.
- Addresses pass through unmodified; out-of-range addresses are not checked.

Decomposition:
- Shared package dmem_arb_pkg holds:
  - the ADDR_W/DATA_W constants;
  - STARVE_LIMIT default;
  - a port-index typedef (PORT_CPU=2'd0, PORT_EXT0=2'd1, PORT_EXT1=2'd2, PORT_NONE=2'd3).
- One sub-module, arb_starve_ctr, instantiated once per ext port.
- Winner mux, rr_ptr and the rvalid pipeline stay in the top module.

Test Plan:
- Reset with both ext_req=1 → no gnt while reset high; on the first cycle after release ext0_gnt=1; next cycle ext1_gnt=1.
- cpu_req=1, cpu_we=1, addr=0x010, wdata=0xDEADBEEF concurrent with ext0 read of 0x010 → mem_wren=1 with CPU values; ext0_gnt=0.
  - Next cycle (cpu_req=0): ext0_gnt=1; one cycle later ext0_rvalid=1 and ext0_rdata=0xDEADBEEF.
- ext0 and ext1 continuous reads of 0x001/0x002 for 6 cycles, no CPU → grants alternate 0,1,0,1,0,1; rvalid alternates one cycle behind with the correct data.
- cpu_req held high for 70 cycles with ext1_req=1 → ext1_starve rises in cycle 64 of waiting; it clears the cycle after cpu_req drops and ext1_gnt fires.
- ext0 read granted, reset asserted the following cycle → ext0_rvalid=0 and rr_ptr=0 afterward; no mem_wren during reset.
- ext1 write 0x0A5 ← 0x12345678, then ext1 read 0x0A5 back-to-back → ext1_rvalid on the cycle after the read grant only, data=0x12345678.
